// File: rtl/mt_rnum_stream.sv
`default_nettype none
// ============================================================================
// Module   : mt_rnum_stream
// Purpose  : Buffers 32-bit words from the Mersenne-twister generator in a
//            DEPTH-word FIFO. Each word leaves as OUT_W-bit chunks on a
//            valid/ready stream, LSB chunk first. Cycles where the consumer
//            is ready but no chunk is available are counted, saturating.
// Revision : 1.0  initial release
// ============================================================================
module mt_rnum_stream #(
  parameter int DEPTH = 8,
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       gen_ready,
  input  logic [31:0]                gen_num,
  output logic                       gen_trig,
  input  logic                       flush,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [OUT_W-1:0]           m_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int CHUNKS = 32 / OUT_W;
  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = $clog2(DEPTH + 1);
  localparam int SW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  logic [31:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [SW-1:0]    sub_q, sub_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             push;
  logic             pop_chunk;
  logic             pop_word;
  logic             last_chunk;
  logic             starved;
  logic [31:0]      head_word;
  logic [OUT_W-1:0] head_chunk;

  // Push depends only on registered level, so a full FIFO popping its last
  // chunk pushes one cycle later rather than creating an m_ready->trig path.
  assign gen_trig  = gen_ready & ~flush & ~rst & (level_q < LW'(DEPTH));
  assign push      = gen_trig;
  assign m_valid   = (level_q != '0) & ~flush & ~rst;
  assign pop_chunk = m_valid & m_ready;
  assign pop_word  = pop_chunk & last_chunk;
  assign starved   = m_ready & ~m_valid & ~flush;
  assign head_word = mem_q[rd_ptr_q];
  assign m_data    = m_valid ? head_chunk : '0;
  assign level     = level_q;
  assign stall_cnt = stall_cnt_q;

  generate
    if (CHUNKS == 1) begin : g_whole
      assign head_chunk = head_word;
      assign last_chunk = 1'b1;
    end else begin : g_split
      // Select the chunk of the head word addressed by the chunk index
      always_comb begin
        head_chunk = '0;
        for (int i = 0; i < CHUNKS; i++) begin
          if (sub_q == SW'(i)) head_chunk = head_word[i*OUT_W +: OUT_W];
        end
      end
      assign last_chunk = (sub_q == SW'(CHUNKS - 1));
    end
  endgenerate

  // Next-state for pointers, occupancy, chunk index and starvation counter
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    sub_d       = sub_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      sub_d       = '0;
      stall_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_chunk) sub_d = last_chunk ? '0 : sub_q + SW'(1);
      if (pop_word) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop_word) begin
        level_d = level_q + LW'(1);
      end else if (!push && pop_word) begin
        level_d = level_q - LW'(1);
      end
      if (starved && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Control state registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      sub_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      sub_q       <= sub_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Word storage; contents are only meaningful below the level count
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= gen_num;
  end

endmodule
`default_nettype wire
